// File: rtl/decrypt_seq_pkg.sv
// Shared LWE decrypt definitions: parameter constants, sequencer state
// encoding and the chunk-count helper used to size the fetch loop.
// Latency: n/a (package). Backpressure: n/a.
package decrypt_seq_pkg;

    // LWE parameter set used by the decrypt datapath.
    localparam int LWE_DIMENSION = 10;
    localparam int LWE_DIM_WIDTH = 4;
    localparam int LWE_PT_WIDTH  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Number of memory chunks needed to cover indices 0..dimension when
    // 'parallel' entries are consumed per chunk: ceil((dimension+1)/parallel).
    function automatic int nchunk(input int dimension, input int parallel);
        return (dimension + parallel) / parallel;
    endfunction

endpackage

// File: rtl/decrypt_seq_if.sv
// Decrypt sequencer bus: request/busy, key+ciphertext memory read port,
// datapath control/result and plaintext valid/ready output.
// Latency: n/a (wiring only). Backpressure: pt_ready stalls the plaintext output.
interface decrypt_seq_if
    import decrypt_seq_pkg::*;
#(
    parameter int PLAINTEXT_WIDTH = LWE_PT_WIDTH,
    parameter int DIM_WIDTH       = LWE_DIM_WIDTH,
    parameter int PARALLEL        = 1
);
    logic                       start;
    logic                       busy;
    logic                       mem_rd_en;
    logic [DIM_WIDTH:0]         mem_addr;
    logic                       dp_en;
    logic [DIM_WIDTH:0]         dp_row;
    logic [PARALLEL-1:0]        dp_lane_zero;
    logic [PLAINTEXT_WIDTH-1:0] dp_result;
    logic [PLAINTEXT_WIDTH-1:0] pt_out;
    logic                       pt_valid;
    logic                       pt_ready;

    // Sequencer side.
    modport master (
        input  start, dp_result, pt_ready,
        output busy, mem_rd_en, mem_addr, dp_en, dp_row, dp_lane_zero,
               pt_out, pt_valid
    );

    // Requester / memory / datapath / consumer side.
    modport slave (
        output start, dp_result, pt_ready,
        input  busy, mem_rd_en, mem_addr, dp_en, dp_row, dp_lane_zero,
               pt_out, pt_valid
    );
endinterface

// File: rtl/decrypt_seq.sv
// LWE decrypt sequencer: streams NCHUNK memory chunks into the dot-product
// datapath and captures the plaintext; NCHUNK+3 cycles from start to pt_valid.
// Backpressure: pt_valid/pt_out hold in OUT until pt_ready; start ignored unless IDLE.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   bus.start/busy      decrypt request (sampled in IDLE) / not-IDLE flag
//   bus.mem_rd_en/addr  chunk read strobe and index (data returns 1 cycle later)
//   bus.dp_en/row/lane_zero  datapath accumulate control, aligned with read data
//   bus.dp_result       datapath result, captured in DRAIN
//   bus.pt_out/valid/ready   plaintext output handshake
module decrypt_seq
    import decrypt_seq_pkg::*;
#(
    parameter int PLAINTEXT_WIDTH = LWE_PT_WIDTH,
    parameter int DIMENSION       = LWE_DIMENSION,
    parameter int DIM_WIDTH       = LWE_DIM_WIDTH,
    parameter int PARALLEL        = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    decrypt_seq_if.master bus
);

    localparam int NCHUNK = nchunk(DIMENSION, PARALLEL);
    localparam int CW     = DIM_WIDTH + 1;
    // Lane index row*PARALLEL+i needs log2(PARALLEL) bits beyond the row width.
    localparam int IDXW   = DIM_WIDTH + 1 + $clog2(PARALLEL);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    state_t                     state_q;
    logic [CW-1:0]              cnt_q;
    logic                       busy_q;
    logic                       mem_rd_en_q;
    logic [CW-1:0]              mem_addr_q;
    logic                       dp_en_q;
    logic [CW-1:0]              dp_row_q;
    logic [PARALLEL-1:0]        dp_lane_zero_q;
    logic [PLAINTEXT_WIDTH-1:0] pt_out_q;
    logic                       pt_valid_q;

    // Lanes of the final chunk that fall past index DIMENSION read padding
    // entries; the datapath must treat them as zero.
    function automatic logic [PARALLEL-1:0] lane_mask(input logic [CW-1:0] row);
        logic [PARALLEL-1:0] m;
        logic [IDXW-1:0]     idx;
        m = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            idx  = IDXW'(row) * IDXW'(PARALLEL) + IDXW'(i);
            m[i] = (idx > IDXW'(DIMENSION));
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            mem_rd_en_q    <= 1'b0;
            mem_addr_q     <= '0;
            dp_en_q        <= 1'b0;
            dp_row_q       <= '0;
            dp_lane_zero_q <= '0;
            pt_out_q       <= '0;
            pt_valid_q     <= 1'b0;
        end else begin
            // Datapath controls trail the read strobe by one cycle so they
            // arrive together with the returned memory data.
            dp_en_q        <= mem_rd_en_q;
            dp_row_q       <= mem_addr_q;
            dp_lane_zero_q <= mem_rd_en_q ? lane_mask(mem_addr_q) : '0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q     <= ST_FETCH;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        mem_rd_en_q <= 1'b1;
                        mem_addr_q  <= '0;
                    end
                end
                ST_FETCH: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CHUNK) begin
                        state_q     <= ST_WAIT;
                        mem_rd_en_q <= 1'b0;
                        mem_addr_q  <= '0;
                    end else begin
                        mem_addr_q  <= cnt_q + 1'b1;
                    end
                end
                // Last chunk is being accumulated this cycle.
                ST_WAIT: begin
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    pt_out_q   <= bus.dp_result;
                    pt_valid_q <= 1'b1;
                    state_q    <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.pt_ready) begin
                        pt_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    mem_rd_en_q <= 1'b0;
                    pt_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.mem_rd_en    = mem_rd_en_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.dp_en        = dp_en_q;
    assign bus.dp_row       = dp_row_q;
    assign bus.dp_lane_zero = dp_lane_zero_q;
    assign bus.pt_out       = pt_out_q;
    assign bus.pt_valid     = pt_valid_q;

endmodule

// File: tb/tb_decrypt_seq.sv
// Bench for decrypt_seq: PARALLEL=1 and PARALLEL=4 instances driven by a
// behavioural key/ciphertext memory and dot-product datapath model.
// Latency: n/a. Backpressure: pt_ready driven by the stimulus.
module tb_decrypt_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decrypt_seq_if #(.PLAINTEXT_WIDTH(6), .DIM_WIDTH(4), .PARALLEL(1)) b0 ();
    decrypt_seq_if #(.PLAINTEXT_WIDTH(6), .DIM_WIDTH(4), .PARALLEL(4)) b1 ();

    decrypt_seq #(.PLAINTEXT_WIDTH(6), .DIMENSION(10), .DIM_WIDTH(4), .PARALLEL(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    decrypt_seq #(.PLAINTEXT_WIDTH(6), .DIMENSION(10), .DIM_WIDTH(4), .PARALLEL(4))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    // Memory and datapath model.
    int sk_mem [32];
    int ct_mem [32];
    int rd_sk0 = 0, rd_ct0 = 0, acc0 = 0, acc1 = 0, s1;
    int rd_sk1 [4];
    int rd_ct1 [4];

    always @(posedge clk) begin
        if (b0.mem_rd_en) begin
            rd_sk0 <= sk_mem[b0.mem_addr];
            rd_ct0 <= ct_mem[b0.mem_addr];
        end
        if (b0.dp_en)
            acc0 <= ((b0.dp_row == 0) ? 0 : acc0) + (b0.dp_lane_zero[0] ? 0 : rd_sk0 * rd_ct0);
        if (b1.mem_rd_en) begin
            for (int l = 0; l < 4; l++) begin
                rd_sk1[l] <= sk_mem[int'(b1.mem_addr) * 4 + l];
                rd_ct1[l] <= ct_mem[int'(b1.mem_addr) * 4 + l];
            end
        end
        if (b1.dp_en) begin
            s1 = 0;
            for (int l = 0; l < 4; l++)
                if (!b1.dp_lane_zero[l]) s1 += rd_sk1[l] * rd_ct1[l];
            acc1 <= ((b1.dp_row == 0) ? 0 : acc1) + s1;
        end
    end

    assign b0.dp_result = 6'(acc0);
    assign b1.dp_result = 6'(acc1);

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Indices above 10 hold nonzero padding that must be masked.
    task automatic load(input int mode);
        for (int i = 0; i < 32; i++) begin
            if (i > 10) begin
                sk_mem[i] = 5; ct_mem[i] = 5;
            end else begin
                case (mode)
                    0: begin sk_mem[i] = 1;  ct_mem[i] = 1; end
                    1: begin sk_mem[i] = i;  ct_mem[i] = 1; end
                    2: begin sk_mem[i] = i;  ct_mem[i] = i; end
                    3: begin sk_mem[i] = 0;  ct_mem[i] = 0; end
                    4: begin sk_mem[i] = 2;  ct_mem[i] = 3; end
                    default: begin sk_mem[i] = 63; ct_mem[i] = 1; end
                endcase
            end
        end
    endtask

    function automatic logic pv(input int d);
        return (d == 0) ? b0.pt_valid : b1.pt_valid;
    endfunction

    function automatic logic [5:0] po(input int d);
        return (d == 0) ? b0.pt_out : b1.pt_out;
    endfunction

    function automatic logic bz(input int d);
        return (d == 0) ? b0.busy : b1.busy;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) b0.start = v; else b1.start = v;
    endtask

    task automatic set_ready(input int d, input logic v);
        if (d == 0) b0.pt_ready = v; else b1.pt_ready = v;
    endtask

    // One full operation from IDLE; returns to IDLE after the handshake.
    task automatic run_op(input int d, input int exp_pt, input string tag);
        int k;
        set_start(d, 1'b1);
        tick();
        set_start(d, 1'b0);
        k = 1;
        while (!pv(d) && k < 60) begin
            tick();
            k++;
        end
        check({tag, " latency"}, k, (d == 0) ? 14 : 6);
        check({tag, " pt_out"}, po(d), exp_pt);
        set_ready(d, 1'b1);
        tick();
        set_ready(d, 1'b0);
        check({tag, " valid drop"}, pv(d), 0);
        check({tag, " busy drop"}, bz(d), 0);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, " busy"}, b0.busy, 0);
        check({tag, " mem_rd_en"}, b0.mem_rd_en, 0);
        check({tag, " mem_addr"}, b0.mem_addr, 0);
        check({tag, " dp_en"}, b0.dp_en, 0);
        check({tag, " dp_row"}, b0.dp_row, 0);
        check({tag, " dp_lane_zero"}, b0.dp_lane_zero, 0);
        check({tag, " pt_out"}, b0.pt_out, 0);
        check({tag, " pt_valid"}, b0.pt_valid, 0);
    endtask

    typedef struct {
        int mode;
        int exp_pt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int k;
        int seen;

        vecs[0] = '{0, 11};   // 11 * 1*1
        vecs[1] = '{1, 55};   // sum 0..10
        vecs[2] = '{2, 1};    // sum of squares 385 mod 64
        vecs[3] = '{3, 0};
        vecs[4] = '{4, 2};    // 11*6 = 66 mod 64
        vecs[5] = '{5, 53};   // 11*63 = 693 mod 64

        b0.start = 1'b0; b0.pt_ready = 1'b0;
        b1.start = 1'b0; b1.pt_ready = 1'b0;
        load(0);

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        check_zero0("reset");
        check("reset p4 busy", b1.busy, 0);
        check("reset p4 dp_lane_zero", b1.dp_lane_zero, 0);
        rst_n = 1'b1;
        tick();

        // Cycle trace, default parameters.
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            check("trace mem_rd_en", b0.mem_rd_en, (c >= 1 && c <= 11));
            if (c <= 11) check("trace mem_addr", b0.mem_addr, c - 1);
            check("trace dp_en", b0.dp_en, (c >= 2 && c <= 12));
            if (c >= 2 && c <= 12) check("trace dp_row", b0.dp_row, c - 2);
            check("trace pt_valid", b0.pt_valid, (c == 14));
            check("trace busy", b0.busy, 1);
            if (c < 14) tick();
        end
        check("trace pt_out", b0.pt_out, 11);

        // Consumer stall with start asserted: output holds, start ignored.
        b0.start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall pt_valid", b0.pt_valid, 1);
            check("stall pt_out", b0.pt_out, 11);
            check("stall busy", b0.busy, 1);
            check("stall mem_rd_en", b0.mem_rd_en, 0);
        end

        // Handshake with start still high: accepted in the following IDLE cycle.
        b0.pt_ready = 1'b1;
        tick();
        b0.pt_ready = 1'b0;
        check("b2b idle busy", b0.busy, 0);
        check("b2b idle pt_valid", b0.pt_valid, 0);
        check("b2b idle mem_rd_en", b0.mem_rd_en, 0);
        tick();
        b0.start = 1'b0;
        check("b2b fetch mem_rd_en", b0.mem_rd_en, 1);
        check("b2b fetch mem_addr", b0.mem_addr, 0);
        check("b2b fetch busy", b0.busy, 1);
        tick();
        check("b2b dp_en", b0.dp_en, 1);
        check("b2b dp_row", b0.dp_row, 0);
        k = 2;
        while (!b0.pt_valid && k < 60) begin
            tick();
            k++;
        end
        check("b2b latency", k, 14);
        check("b2b pt_out", b0.pt_out, 11);
        b0.pt_ready = 1'b1;
        tick();
        b0.pt_ready = 1'b0;

        // Table of operand patterns on both widths.
        for (int v = 0; v < 6; v++) begin
            load(vecs[v].mode);
            run_op(0, vecs[v].exp_pt, $sformatf("vec%0d p1", v));
            run_op(1, vecs[v].exp_pt, $sformatf("vec%0d p4", v));
        end

        // PARALLEL=4 lane mask trace.
        load(0);
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check("p4 mem_rd_en", b1.mem_rd_en, (c >= 1 && c <= 3));
            check("p4 dp_en", b1.dp_en, (c >= 2 && c <= 4));
            if (c >= 2 && c <= 4) begin
                check("p4 dp_row", b1.dp_row, c - 2);
                check("p4 dp_lane_zero", b1.dp_lane_zero, (c == 4) ? 4'b1000 : 4'b0000);
            end else begin
                check("p4 dp_lane_zero idle", b1.dp_lane_zero, 0);
            end
            check("p4 pt_valid", b1.pt_valid, (c == 6));
            if (c < 6) tick();
        end
        check("p4 pt_out", b1.pt_out, 11);
        b1.pt_ready = 1'b1;
        tick();
        b1.pt_ready = 1'b0;

        // Reset in FETCH at counter 5.
        load(1);
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        repeat (5) tick();
        check("midrst mem_addr before", b0.mem_addr, 5);
        rst_n = 1'b0;
        tick();
        check_zero0("midrst");
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (b0.pt_valid) seen = 1;
        end
        check("midrst no pt_valid", seen, 0);
        run_op(0, 55, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/decrypt_seq.md
DECRYPT_SEQ -- requirements
Module: decrypt_seq

Interface
REQ-001 SHALL have parameter PLAINTEXT_WIDTH, default 6, width of the recovered plaintext.
REQ-002 SHALL have parameter DIMENSION, default 10, so the dot product covers DIMENSION+1 entries, indices 0..DIMENSION.
REQ-003 SHALL have parameter DIM_WIDTH, default 4, so chunk/row indices are DIM_WIDTH+1 bits.
REQ-004 SHALL have parameter PARALLEL, default 1, the number of entries consumed per datapath cycle.
REQ-005 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-007 SHALL have port start, input, 1, the decrypt request; sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port mem_rd_en, output, 1, the key/ciphertext memory read strobe; read data is returned exactly 1 cycle later.
REQ-010 SHALL have port mem_addr, output, DIM_WIDTH+1, the chunk index; the memories return entries chunk*PARALLEL .. chunk*PARALLEL+PARALLEL-1.
REQ-011 SHALL have port dp_en, output, 1, the datapath accumulate enable.
REQ-012 SHALL have port dp_row, output, DIM_WIDTH+1, the datapath row; 0 restarts the accumulation.
REQ-013 SHALL have port dp_lane_zero, output, PARALLEL, a per-lane force-to-zero mask for lanes whose entry index exceeds DIMENSION.
REQ-014 SHALL have port dp_result, input, PLAINTEXT_WIDTH, the datapath result.
REQ-015 SHALL have port pt_out, output, PLAINTEXT_WIDTH, the captured plaintext.
REQ-016 SHALL have port pt_valid, output, 1, qualifying pt_out.
REQ-017 SHALL have port pt_ready, input, 1, the consumer accept.

Function
REQ-018 SHALL define NCHUNK = ceil((DIMENSION+1)/PARALLEL); default NCHUNK = 11.
REQ-019 SHALL implement the states IDLE, FETCH, WAIT, DRAIN and OUT.
REQ-020 SHALL move IDLE->FETCH on start=1, clearing the chunk counter to 0.
REQ-021 SHALL, in FETCH: assert mem_rd_en, drive mem_addr = counter, and increment the counter each cycle; after the cycle with counter = NCHUNK-1, move to WAIT (FETCH lasts exactly NCHUNK cycles).
REQ-022 SHALL register dp_en and dp_row as 1-cycle-delayed copies of mem_rd_en and mem_addr, so read data and dp_row reach the datapath in the same cycle.
REQ-023 SHALL register dp_lane_zero with dp_row; lane i is set iff dp_row*PARALLEL+i > DIMENSION; all lanes are 0 when dp_en=0.
REQ-024 SHALL hold WAIT for 1 cycle (the last dp_en), then move to DRAIN.
REQ-025 SHALL, in DRAIN, capture dp_result into pt_out, then move to OUT.
REQ-026 SHALL hold pt_valid=1 and pt_out stable in OUT until pt_ready=1, then move OUT->IDLE.
REQ-027 SHALL give a latency of NCHUNK+3 cycles from the cycle start is sampled (cycle 0) to the first pt_valid=1 (default: cycle 14).
REQ-028 SHALL ignore start in every non-IDLE state; start arriving with the OUT->IDLE handshake is not accepted until the next IDLE cycle.
REQ-029 SHALL keep mem_rd_en=0 and dp_en=0 in all states other than FETCH and the 1-cycle-delayed echo described in REQ-022.
REQ-030 SHALL compare counter wrap and the lane-index product at DIM_WIDTH+1 bits plus log2(PARALLEL) headroom, with no overflow for DIMENSION < 2^DIM_WIDTH.

Reset
REQ-031 SHALL, when rst_n=0 at a rising edge, set state IDLE, counter 0, busy 0, mem_rd_en 0, mem_addr 0, dp_en 0, dp_row 0, dp_lane_zero 0, pt_out 0 and pt_valid 0.
REQ-032 SHALL, on reset mid-operation, abandon the operation with no pt_valid pulse; the next start runs a full sequence, since row 0 restarts the datapath.
REQ-033 SHALL give reset priority over start and pt_ready in the same cycle.

Structure
REQ-034 SHALL place the state enum and the NCHUNK computation function in the shared package, alongside the existing LWE parameter constants.
REQ-035 SHALL be a single module with no submodules; an integration wrapper instantiates decrypt_seq beside the decrypt datapath.

Verification
REQ-036 SHALL cover: defaults, start pulsed at cycle 0 -> mem_addr 0..10 in cycles 1..11, dp_row 0..10 in cycles 2..12, pt_valid first high in cycle 14.
REQ-037 SHALL cover: datapath model with sk=ct=1 for all 11 entries -> pt_out = 11.
REQ-038 SHALL cover: PARALLEL=4, DIMENSION=10 -> NCHUNK=3, dp_lane_zero = 0000, 0000, 1000 (lane 3 set, index 11) on rows 0, 1, 2.
REQ-039 SHALL cover: pt_ready held low for 5 cycles -> pt_valid and pt_out stable; start during that window is ignored, with busy=1 throughout.
REQ-040 SHALL cover: rst_n low in FETCH at counter = 5 -> next cycle all outputs are 0 and no pt_valid; a fresh start then yields the correct result at +14 cycles.
REQ-041 SHALL cover: back-to-back ops with start held high -> second op accepted in the cycle after OUT->IDLE, and dp_row restarts at 0.
